conv_state_seq: RTL and testbench
=================================

Name: conv_state_seq

Overview:
- Top-level sequencer for the convolution unit.
- Walks one feature-map pass per input-channel group through the states INIT, A (row-buffer fill), B (compute stream), C (pipeline drain) and D (done).
- Drives the 3-bit current_state consumed by the conv control logic, gates the input pixel stream with a valid/ready handshake, and flags valid accumulator outputs.
- Supports 3x3 mode and pointwise (PW) mode.

Parameters:
- CNT_WIDTH, 8: width of the width/height/position counters.
- GRP_WIDTH, 4: width of the channel-group counter.
- MULT_PIPELINE_STAGE, 2: multiplier pipeline depth. Window-to-output latency LAT = MULT_PIPELINE_STAGE+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-high reset (1 = reset asserted).
- state_rst  in  1  synchronous abort from conv control; active-high.
- start  in  1  start pulse; sampled only in INIT.
- cfg_pw  in  1  1 = pointwise mode, 0 = 3x3 mode.
- cfg_width  in  CNT_WIDTH  feature-map width W.
- cfg_height  in  CNT_WIDTH  feature-map height H.
- cfg_groups  in  GRP_WIDTH  number of channel groups G.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  sequencer accepts a pixel.
- current_state  out  3  000 INIT, 001 A, 010 B, 011 C, 100 D.
- out_valid  out  1  accumulator result valid this cycle.
- first_grp  out  1  current group is group 0 (accumulator clears rather than adds).
- last_grp  out  1  current group is G-1.
- line_len  out  CNT_WIDTH  latched W, for row-buffer length control.
- row_cnt  out  CNT_WIDTH  row of the next pixel to be accepted.
- col_cnt  out  CNT_WIDTH  column of the next pixel to be accepted.
- grp_cnt  out  GRP_WIDTH  current group index.
- busy  out  1  current_state != INIT.
- done  out  1  one-cycle pulse in D.
- cfg_err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (rstn=1, async): current_state=INIT. All counters, line_len, out_valid, done, cfg_err, in_ready, first_grp and last_grp go to 0. The LAT shift register is cleared.
- Beat definition: beat = in_valid & in_ready. in_ready=1 only in A and B. in_valid may toggle freely; counters advance only on a beat.
- INIT: on start, check config.
  - Invalid if W=0, H=0 or G=0 (either mode), or W<3 or H<3 (3x3 mode). Invalid start: pulse cfg_err next cycle, stay in INIT.
  - Valid start: latch W, H, G and pw. Clear row, column and group counters. Next state is B if pw, else A.
- A (fill, 3x3 only): accepts 2W+2 beats (rows 0 and 1, plus pixels (2,0) and (2,1)). Row/col counters advance, with col wrapping at W-1 and incrementing row. On the beat that brings the fill count to 2W+2, go to B (next pixel is (2,2)). No windows are produced in A.
- B (compute): each beat is a window beat if pw=1, or if pw=0 and col_cnt>=2 for that pixel. A window beat enters the LAT shift register. On the beat at row H-1, col W-1, go to C.
- Output timing: out_valid equals the window beat delayed by exactly LAT cycles.
- C (drain): in_ready=0. Stay LAT+1 cycles.
  - If grp_cnt == G-1: go to D.
  - Otherwise: grp_cnt+1, clear row/col, go to A (3x3) or B (pw).
- D: done=1 for one cycle, then INIT. busy falls in the same cycle current_state returns to INIT.
- first_grp and last_grp: derived from grp_cnt and the latched G. Valid in A, B and C.
- state_rst:
  - In any state except INIT: next cycle current_state=INIT. Counters are cleared, the shift register is flushed (out_valid=0 from the next cycle), and no done pulse is issued.
  - state_rst takes precedence over a coincident start, beat or state transition.
- Config inputs are ignored outside INIT; changing them mid-pass has no effect.
- Counters never exceed W-1 / H-1. There is no wrap past the last pixel, because the state exits first.

Test Plan:
- 3x3 mode, W=4, H=4, G=1, in_valid held at 1 → A lasts 10 cycles, B lasts 6 cycles. out_valid pulses 4 times, for pixels (2,2), (2,3), (3,2), (3,3), each LAT=3 cycles after its beat. C lasts 4 cycles, then a single done pulse, then INIT.
- PW mode, W=2, H=2, G=2 → no A state. B accepts 4 beats with 4 out_valid pulses; C; B again with grp_cnt=1 and last_grp=1; 4 more out_valid pulses; done. first_grp=1 only during group 0.
- Backpressure: 3x3, W=3, H=3, in_valid toggling 1,0,1,0 → total beats = 9, row_cnt/col_cnt hold while in_valid=0, and exactly 1 out_valid pulse (pixel (2,2)).
- Abort: assert state_rst in the third B cycle of the first scenario → next cycle INIT, in_ready=0, no further out_valid, no done. A following start runs a normal pass.
- Config errors:
  - start with cfg_pw=0, W=2 → cfg_err pulse, state remains INIT, busy=0.
  - start with G=0 → same response.
- Async reset: rstn pulsed mid-B, asynchronously to clk → outputs go to their reset values immediately, with no wait for a clock edge.

Source files
------------

// File: rtl/conv_state_seq_if.sv
// Pixel-stream handshake between the feature-map source and the convolution
// sequencer.
//   in_valid : source has a pixel this cycle
//   in_ready : sequencer accepts a pixel this cycle
// A pixel moves (a "beat") when both are high in the same cycle.
interface conv_state_seq_if;
  logic in_valid;
  logic in_ready;

  modport master (output in_valid, input in_ready);
  modport slave  (input in_valid, output in_ready);
endinterface

// File: rtl/conv_state_seq.sv
// Top-level sequencer for the convolution unit.
// It walks one feature-map pass per input-channel group through
// INIT -> A (row-buffer fill, 3x3 only) -> B (compute) -> C (drain) -> D (done).
// It gates the pixel stream and flags valid accumulator outputs LAT cycles
// after each window beat.
// Ports:
//   clk, rstn            clock; asynchronous active-high reset
//   state_rst            synchronous abort back to INIT
//   start                pass start, sampled only in INIT
//   cfg_pw/width/height/groups  pass configuration, latched on a valid start
//   pix (slave)          pixel handshake: in_valid in, in_ready out
//   current_state        000 INIT, 001 A, 010 B, 011 C, 100 D
//   out_valid            accumulator result valid
//   first_grp/last_grp   group 0 / group G-1 flags
//   line_len             latched width, used by the row buffers
//   row_cnt/col_cnt      position of the next pixel to be accepted
//   grp_cnt              current channel group
//   busy, done, cfg_err  status: not idle / pass finished / start rejected
module conv_state_seq #(
  parameter int CNT_WIDTH           = 8,
  parameter int GRP_WIDTH           = 4,
  parameter int MULT_PIPELINE_STAGE = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 state_rst,
  input  logic                 start,
  input  logic                 cfg_pw,
  input  logic [CNT_WIDTH-1:0] cfg_width,
  input  logic [CNT_WIDTH-1:0] cfg_height,
  input  logic [GRP_WIDTH-1:0] cfg_groups,
  conv_state_seq_if.slave      pix,
  output logic [2:0]           current_state,
  output logic                 out_valid,
  output logic                 first_grp,
  output logic                 last_grp,
  output logic [CNT_WIDTH-1:0] line_len,
  output logic [CNT_WIDTH-1:0] row_cnt,
  output logic [CNT_WIDTH-1:0] col_cnt,
  output logic [GRP_WIDTH-1:0] grp_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam int LAT   = MULT_PIPELINE_STAGE + 1;
  localparam int DRN_W = $clog2(LAT + 1) + 1;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_C    = 3'd3,
    S_D    = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] h_len;
  logic [GRP_WIDTH-1:0] g_num;
  logic                 pw_mode;
  logic [LAT-1:0]       win_sr;
  logic [DRN_W-1:0]     drn_cnt;
  logic                 ready;

  logic beat, abort, cfg_ok, start_ok, col_end, row_end;
  logic fill_end, pass_end, drain_end, grp_end, win;

  assign pix.in_ready = ready;
  assign beat     = pix.in_valid & ready;
  assign abort    = state_rst && (state != S_INIT);
  assign cfg_ok   = (cfg_width != '0) && (cfg_height != '0) && (cfg_groups != '0) &&
                    (cfg_pw || ((cfg_width >= CNT_WIDTH'(3)) && (cfg_height >= CNT_WIDTH'(3))));
  // state_rst also blocks a start that arrives in INIT.
  assign start_ok = (state == S_INIT) && start && !state_rst && cfg_ok;
  assign col_end  = (col_cnt == line_len - CNT_WIDTH'(1));
  assign row_end  = (row_cnt == h_len - CNT_WIDTH'(1));
  // Fill ends on pixel (2,1): rows 0 and 1 plus two pixels of row 2 = 2W+2 beats.
  assign fill_end = beat && (state == S_A) &&
                    (row_cnt == CNT_WIDTH'(2)) && (col_cnt == CNT_WIDTH'(1));
  assign pass_end = beat && (state == S_B) && col_end && row_end;
  assign drain_end = (state == S_C) && (drn_cnt == DRN_W'(LAT));
  assign grp_end  = (grp_cnt == g_num - GRP_WIDTH'(1));
  // In 3x3 mode the first two columns of a row do not complete a window.
  assign win      = beat && (state == S_B) && (pw_mode || (col_cnt >= CNT_WIDTH'(2)));

  // State register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state <= S_INIT;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (start_ok) state_nxt = cfg_pw ? S_B : S_A;
      S_A:    if (fill_end) state_nxt = S_B;
      S_B:    if (pass_end) state_nxt = S_C;
      S_C:    if (drain_end) state_nxt = grp_end ? S_D : (pw_mode ? S_B : S_A);
      S_D:    state_nxt = S_INIT;
      default: state_nxt = S_INIT;
    endcase
    if (abort) state_nxt = S_INIT;
  end

  // Output decode
  always_comb begin
    current_state = state;
    ready         = (state == S_A) || (state == S_B);
    busy          = (state != S_INIT);
    done          = (state == S_D);
    first_grp     = ((state == S_A) || (state == S_B) || (state == S_C)) && (grp_cnt == '0);
    last_grp      = ((state == S_A) || (state == S_B) || (state == S_C)) && grp_end;
    out_valid     = win_sr[LAT-1];
  end

  // Counters, configuration latches and the window-latency shift register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      line_len <= '0;
      h_len    <= '0;
      g_num    <= '0;
      pw_mode  <= 1'b0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      grp_cnt  <= '0;
      drn_cnt  <= '0;
      win_sr   <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= (state == S_INIT) && start && !state_rst && !cfg_ok;
      win_sr  <= abort ? '0 : ((win_sr << 1) | LAT'(win));
      if (abort || (state == S_D)) begin
        row_cnt <= '0;
        col_cnt <= '0;
        grp_cnt <= '0;
        drn_cnt <= '0;
      end else begin
        case (state)
          S_INIT: begin
            if (start_ok) begin
              line_len <= cfg_width;
              h_len    <= cfg_height;
              g_num    <= cfg_groups;
              pw_mode  <= cfg_pw;
              row_cnt  <= '0;
              col_cnt  <= '0;
              grp_cnt  <= '0;
            end
          end
          S_A, S_B: begin
            if (beat) begin
              if (col_end) begin
                col_cnt <= '0;
                // The last pixel of the map leaves B, so row wraps to 0 instead of H.
                row_cnt <= row_end ? '0 : row_cnt + CNT_WIDTH'(1);
              end else begin
                col_cnt <= col_cnt + CNT_WIDTH'(1);
              end
            end
          end
          S_C: begin
            if (drain_end) begin
              drn_cnt <= '0;
              row_cnt <= '0;
              col_cnt <= '0;
              if (!grp_end) grp_cnt <= grp_cnt + GRP_WIDTH'(1);
            end else begin
              drn_cnt <= drn_cnt + DRN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_state_seq.sv
// Directed testbench for conv_state_seq: reset values, 3x3 and pointwise
// passes, backpressure, abort, configuration errors and asynchronous reset.
module tb_conv_state_seq;
  logic       clk = 1'b0;
  logic       rstn;
  logic       state_rst;
  logic       start;
  logic       cfg_pw;
  logic [7:0] cfg_width;
  logic [7:0] cfg_height;
  logic [3:0] cfg_groups;
  logic [2:0] current_state;
  logic       out_valid, first_grp, last_grp, busy, done, cfg_err;
  logic [7:0] line_len, row_cnt, col_cnt;
  logic [3:0] grp_cnt;

  int vectors     = 0;
  int miscompares = 0;

  conv_state_seq_if pix ();

  conv_state_seq #(.CNT_WIDTH(8), .GRP_WIDTH(4), .MULT_PIPELINE_STAGE(2)) dut (
    .clk(clk), .rstn(rstn), .state_rst(state_rst), .start(start),
    .cfg_pw(cfg_pw), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_groups(cfg_groups), .pix(pix), .current_state(current_state),
    .out_valid(out_valid), .first_grp(first_grp), .last_grp(last_grp),
    .line_len(line_len), .row_cnt(row_cnt), .col_cnt(col_cnt),
    .grp_cnt(grp_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic pw, input logic [7:0] w, input logic [7:0] h,
                         input logic [3:0] g);
    cfg_pw = pw; cfg_width = w; cfg_height = h; cfg_groups = g;
  endtask

  // 3x3, W=H=4, G=1, in_valid held high. abort_c >= 0 raises state_rst in that cycle.
  task automatic run_4x4(input int abort_c);
    logic [2:0] es;
    logic       eov, edn;
    @(negedge clk);
    set_cfg(1'b0, 8'd4, 8'd4, 4'd1);
    start = 1'b1;
    pix.in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (abort_c >= 0 && c > abort_c) begin
        es = 3'd0; eov = 1'b0; edn = 1'b0;
      end else begin
        es  = (c < 10) ? 3'd1 : (c < 16) ? 3'd2 : (c < 20) ? 3'd3 : (c == 20) ? 3'd4 : 3'd0;
        eov = (c == 13) || (c == 14) || (c == 17) || (c == 18);
        edn = (c == 20);
      end
      chk($sformatf("p4 c%0d state", c), 32'(current_state), 32'(es));
      chk($sformatf("p4 c%0d out_valid", c), 32'(out_valid), 32'(eov));
      chk($sformatf("p4 c%0d done", c), 32'(done), 32'(edn));
      chk($sformatf("p4 c%0d busy", c), 32'(busy), 32'(es != 3'd0));
      chk($sformatf("p4 c%0d in_ready", c), 32'(pix.in_ready), 32'(es == 3'd1 || es == 3'd2));
      chk($sformatf("p4 c%0d first_grp", c), 32'(first_grp), 32'(es >= 3'd1 && es <= 3'd3));
      chk($sformatf("p4 c%0d last_grp", c), 32'(last_grp), 32'(es >= 3'd1 && es <= 3'd3));
      if (c == 0) chk("p4 cfg_err on valid start", 32'(cfg_err), 32'd0);
      if (c == 0) chk("p4 line_len", 32'(line_len), 32'd4);
      if (c == 10) chk("p4 row at B entry", 32'(row_cnt), 32'd2);
      if (c == 10) chk("p4 col at B entry", 32'(col_cnt), 32'd2);
      state_rst = (c == abort_c);
      @(negedge clk);
    end
    state_rst = 1'b0;
    pix.in_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] es;
    int         beats, ovs;
    rstn = 1'b1; state_rst = 1'b0; start = 1'b0; pix.in_valid = 1'b0;
    set_cfg(1'b0, 8'd0, 8'd0, 4'd0);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst state", 32'(current_state), 32'd0);
    chk("rst in_ready", 32'(pix.in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst cfg_err", 32'(cfg_err), 32'd0);
    chk("rst line_len", 32'(line_len), 32'd0);
    chk("rst counters", {row_cnt, col_cnt, 4'(grp_cnt), 4'd0, 8'd0}, 32'd0);
    chk("rst grp flags", {30'd0, first_grp, last_grp}, 32'd0);
    rstn = 1'b0;

    // 3x3 pass
    run_4x4(-1);

    // Pointwise pass, W=2, H=2, G=2
    @(negedge clk);
    set_cfg(1'b1, 8'd2, 8'd2, 4'd2);
    start = 1'b1;
    pix.in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 18; c++) begin
      es = (c < 4) ? 3'd2 : (c < 8) ? 3'd3 : (c < 12) ? 3'd2 : (c < 16) ? 3'd3 :
           (c == 16) ? 3'd4 : 3'd0;
      chk($sformatf("pw c%0d state", c), 32'(current_state), 32'(es));
      chk($sformatf("pw c%0d out_valid", c), 32'(out_valid),
          32'((c >= 3 && c <= 6) || (c >= 11 && c <= 14)));
      chk($sformatf("pw c%0d first_grp", c), 32'(first_grp), 32'(c < 8));
      chk($sformatf("pw c%0d last_grp", c), 32'(last_grp), 32'(c >= 8 && c < 16));
      chk($sformatf("pw c%0d done", c), 32'(done), 32'(c == 16));
      if (c < 16) chk($sformatf("pw c%0d grp_cnt", c), 32'(grp_cnt), 32'(c >= 8));
      @(negedge clk);
    end
    pix.in_valid = 1'b0;

    // Backpressure, 3x3, W=H=3, G=1, in_valid 1,0,1,0...
    @(negedge clk);
    set_cfg(1'b0, 8'd3, 8'd3, 4'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    ovs   = 0;
    for (int c = 0; c < 23; c++) begin
      pix.in_valid = (c % 2 == 0);
      es = (c < 15) ? 3'd1 : (c < 17) ? 3'd2 : (c < 21) ? 3'd3 : (c == 21) ? 3'd4 : 3'd0;
      chk($sformatf("bp c%0d state", c), 32'(current_state), 32'(es));
      chk($sformatf("bp c%0d out_valid", c), 32'(out_valid), 32'(c == 19));
      if (c == 1 || c == 2) chk($sformatf("bp c%0d col hold", c), 32'(col_cnt), 32'd1);
      if (c == 5) chk("bp c5 row", 32'(row_cnt), 32'd1);
      if (c == 5) chk("bp c5 col", 32'(col_cnt), 32'd0);
      if (c == 16) chk("bp c16 pos", {16'd0, row_cnt, col_cnt}, 32'h0202);
      if (pix.in_valid && pix.in_ready) beats++;
      if (out_valid) ovs++;
      @(negedge clk);
    end
    pix.in_valid = 1'b0;
    chk("bp total beats", 32'(beats), 32'd9);
    chk("bp out_valid pulses", 32'(ovs), 32'd1);

    // Abort in the third B cycle, then a normal pass
    run_4x4(12);
    run_4x4(-1);

    // Configuration errors
    @(negedge clk);
    set_cfg(1'b0, 8'd2, 8'd4, 4'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg W=2 cfg_err", 32'(cfg_err), 32'd1);
    chk("cfg W=2 state", 32'(current_state), 32'd0);
    chk("cfg W=2 busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cfg W=2 cfg_err pulse", 32'(cfg_err), 32'd0);
    set_cfg(1'b1, 8'd4, 8'd4, 4'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg G=0 cfg_err", 32'(cfg_err), 32'd1);
    chk("cfg G=0 state", 32'(current_state), 32'd0);
    chk("cfg G=0 busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cfg G=0 cfg_err pulse", 32'(cfg_err), 32'd0);

    // Asynchronous reset in the middle of B
    set_cfg(1'b0, 8'd4, 8'd4, 4'd1);
    start = 1'b1;
    pix.in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("ar pre state", 32'(current_state), 32'd2);
    chk("ar pre out_valid", 32'(out_valid), 32'd1);
    #2 rstn = 1'b1;
    #1;
    chk("ar state", 32'(current_state), 32'd0);
    chk("ar out_valid", 32'(out_valid), 32'd0);
    chk("ar in_ready", 32'(pix.in_ready), 32'd0);
    chk("ar busy", 32'(busy), 32'd0);
    chk("ar counters", {row_cnt, col_cnt, 4'(grp_cnt), 4'd0, line_len}, 32'd0);
    chk("ar grp flags", {30'd0, first_grp, last_grp}, 32'd0);
    @(negedge clk);
    rstn = 1'b0;
    pix.in_valid = 1'b0;
    @(negedge clk);
    chk("ar after release state", 32'(current_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
